// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the max-pool channel sequencer.
package maxpool_pkg;

  typedef logic signed [7:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

  function automatic int map_size(input int w);
    return w * w;
  endfunction

endpackage

// File: rtl/maxpool_channel_sequencer.sv
// Drives one shared 2x2/stride-2 pool engine across every channel of a layer.
// Optional cycle counter enabled by defining MAXPOOL_SEQ_PERF_EN.
module maxpool_channel_sequencer
  import maxpool_pkg::*;
#(
  parameter int MAP_WIDTH = 28,
  parameter int OUT_DIM   = MAP_WIDTH / 2,
  parameter int ADDR_W    = 16,
  parameter int CH_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   num_channels,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  pixel_t            rd_data,
  output logic              eng_rst,
  output logic              eng_valid_in,
  output pixel_t            eng_pixel_in,
  input  logic              eng_valid_out,
  input  pixel_t            eng_pixel_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output pixel_t            wr_data,
  output logic              busy,
`ifdef MAXPOOL_SEQ_PERF_EN
  output logic [31:0]       cycle_count,
`endif
  output logic              done
);

  localparam int PIX_CNT = map_size(MAP_WIDTH);
  localparam int OUT_CNT = map_size(OUT_DIM);
  localparam int PIX_W   = $clog2(PIX_CNT);
  localparam int OUT_W   = $clog2(OUT_CNT + 1);

  localparam logic [ADDR_W-1:0] PIX_CNT_A = ADDR_W'(PIX_CNT);
  localparam logic [ADDR_W-1:0] OUT_CNT_A = ADDR_W'(OUT_CNT);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_CNT - 1);
  localparam logic [OUT_W-1:0]  OUT_FULL  = OUT_W'(OUT_CNT);

  seq_state_t        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   num_ch_q, num_ch_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [PIX_W-1:0]  pix_idx_q, pix_idx_d;
  logic [OUT_W-1:0]  out_idx_q, out_idx_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              eng_rst_q, eng_rst_d;
  logic              done_q, done_d;
  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  pixel_t            pix_p2_q, pix_p2_d;
  logic [ADDR_W-1:0] ch_ext;
  logic              accept;

  assign ch_ext = ADDR_W'(ch_q);
  // Results only count while a channel is in flight; strays elsewhere are dropped.
  assign accept = eng_valid_out && ((state_q == STREAM) || (state_q == DRAIN));

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    num_ch_d   = num_ch_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    pix_idx_d  = pix_idx_q;
    out_idx_d  = out_idx_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    eng_rst_d  = 1'b0;
    done_d     = 1'b0;
    vld_p1_d   = rd_en_q && rd_gnt;
    vld_p2_d   = vld_p1_q;
    pix_p2_d   = rd_data;

    if (accept) out_idx_d = out_idx_q + OUT_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          num_ch_d   = num_channels;
          in_base_d  = in_base;
          out_base_d = out_base;
          ch_d       = '0;
          if (num_channels == '0) begin
            state_d = DONE;
          end else begin
            state_d   = CLEAR;
            eng_rst_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        pix_idx_d = '0;
        out_idx_d = '0;
        rd_en_d   = 1'b1;
        rd_addr_d = in_base_q + ch_ext * PIX_CNT_A;
        state_d   = STREAM;
      end
      STREAM: begin
        if (rd_en_q && rd_gnt) begin
          if (pix_idx_q == PIX_LAST) begin
            rd_en_d = 1'b0;
            state_d = DRAIN;
          end else begin
            pix_idx_d = pix_idx_q + PIX_W'(1);
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_idx_q == OUT_FULL) begin
          if (ch_q == num_ch_q - CH_W'(1)) begin
            state_d = DONE;
          end else begin
            ch_d      = ch_q + CH_W'(1);
            state_d   = CLEAR;
            eng_rst_d = 1'b1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      num_ch_q   <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      pix_idx_q  <= '0;
      out_idx_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      eng_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      pix_p2_q   <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      num_ch_q   <= num_ch_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      pix_idx_q  <= pix_idx_d;
      out_idx_q  <= out_idx_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      eng_rst_q  <= eng_rst_d;
      done_q     <= done_d;
      // p1: grant seen, SRAM data arrives; p2: strobe and pixel presented together
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      pix_p2_q   <= pix_p2_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign eng_rst      = eng_rst_q;
  assign eng_valid_in = vld_p2_q;
  assign eng_pixel_in = pix_p2_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
  assign wr_en        = accept;
  assign wr_data      = accept ? eng_pixel_out : '0;
  assign wr_addr      = out_base_q + ch_ext * OUT_CNT_A + ADDR_W'(out_idx_q);

`ifdef MAXPOOL_SEQ_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    if ((state_q == IDLE) && start) cycle_count_d = '0;
    else if (busy) cycle_count_d = cycle_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cycle_count_q <= '0;
    else     cycle_count_q <= cycle_count_d;
  end

  assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_maxpool_channel_sequencer.sv
// Bench for maxpool_channel_sequencer with an SRAM model and a behavioural 2x2 pool engine.
module tb_maxpool_channel_sequencer;

  localparam int MW = 4;
  localparam int AW = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CW-1:0]     num_channels = '0;
  logic [AW-1:0]     in_base = '0;
  logic [AW-1:0]     out_base = '0;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              rd_gnt = 1'b1;
  logic signed [7:0] rd_data = '0;
  logic              eng_rst;
  logic              eng_valid_in;
  logic signed [7:0] eng_pixel_in;
  logic              eng_valid_out;
  logic signed [7:0] eng_pixel_out;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic signed [7:0] wr_data;
  logic              busy;
  logic              done;
`ifdef MAXPOOL_SEQ_PERF_EN
  logic [31:0]       cycle_count;
`endif

  maxpool_channel_sequencer #(.MAP_WIDTH(MW), .ADDR_W(AW), .CH_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_channels(num_channels),
    .in_base(in_base), .out_base(out_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
    .eng_rst(eng_rst), .eng_valid_in(eng_valid_in), .eng_pixel_in(eng_pixel_in),
    .eng_valid_out(eng_valid_out), .eng_pixel_out(eng_pixel_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
`ifdef MAXPOOL_SEQ_PERF_EN
    .cycle_count(cycle_count),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input SRAM: data one cycle after a granted request
  logic [7:0] mem [0:255];
  always @(posedge clk) if (rd_en && rd_gnt) rd_data <= mem[rd_addr];

  function automatic logic signed [7:0] smax(input logic signed [7:0] a, input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Pool engine: row buffer of pair maxima, result strobed with the 4th pixel of a window
  logic [1:0]        e_col = '0, e_row = '0;
  logic signed [7:0] e_buf [0:1];
  logic signed [7:0] e_acc = '0;

  always_comb begin
    eng_valid_out = eng_valid_in && !eng_rst && e_row[0] && e_col[0];
    eng_pixel_out = smax(e_acc, eng_pixel_in);
  end

  always @(posedge clk) begin
    if (rst || eng_rst) begin
      e_col <= '0;
      e_row <= '0;
    end else if (eng_valid_in) begin
      if (!e_row[0]) begin
        if (!e_col[0]) e_acc <= eng_pixel_in;
        else           e_buf[e_col[1]] <= smax(e_acc, eng_pixel_in);
      end else if (!e_col[0]) begin
        e_acc <= smax(e_buf[e_col[1]], eng_pixel_in);
      end
      if (e_col == 2'd3) e_row <= e_row + 2'd1;
      e_col <= e_col + 2'd1;
    end
  end

  // Scoreboard and event counters, sampled on the falling edge
  exp_t exp_q[$];
  bit   ignore_wr = 1'b0;
  int   cyc = 0, vin_cnt = 0, erst_cnt = 0, rd_cnt = 0, wr_cnt = 0, gnt_cnt = 0, done_cnt = 0;
  int   last_gnt_cyc = 0, last_wr_cyc = 0;
  logic prev_rd_en = 1'b0, prev_gnt = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (!ignore_wr) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_wr", {24'd0, wr_addr}, 32'hffff_ffff);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
            chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
          end
        end
      end
      if (rd_en && prev_rd_en && !prev_gnt) chk("rd_addr_hold", {24'd0, rd_addr}, {24'd0, prev_addr});
      if (eng_valid_in) vin_cnt++;
      if (eng_rst) erst_cnt++;
      if (rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (rd_en && rd_gnt) begin
        gnt_cnt++;
        last_gnt_cyc = cyc;
      end
    end
    prev_rd_en = rd_en;
    prev_gnt   = rd_gnt;
    prev_addr  = rd_addr;
  end

  task automatic clear_counts();
    vin_cnt = 0; erst_cnt = 0; rd_cnt = 0; wr_cnt = 0; gnt_cnt = 0; done_cnt = 0;
  endtask

  task automatic push_expected(input int nch, input logic [7:0] inb, input logic [7:0] outb);
    for (int ch = 0; ch < nch; ch++)
      for (int oy = 0; oy < 2; oy++)
        for (int ox = 0; ox < 2; ox++) begin
          exp_t e;
          logic signed [7:0] m;
          logic [7:0] a;
          a = inb + 8'(ch * 16 + oy * 8 + ox * 2);
          m = mem[a];
          m = smax(m, mem[a + 8'd1]);
          m = smax(m, mem[a + 8'd4]);
          m = smax(m, mem[a + 8'd5]);
          e.addr = outb + 8'(ch * 4 + oy * 2 + ox);
          e.data = m;
          exp_q.push_back(e);
        end
  endtask

  task automatic pulse_start(input int nch, input logic [7:0] inb, input logic [7:0] outb);
    num_channels = CW'(nch);
    in_base      = inb;
    out_base     = outb;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, input string tag);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      else rd_gnt = toggle ? ~rd_gnt : 1'b1;
      n++;
    end
    rd_gnt = 1'b1;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_all_written"}, exp_q.size(), 32'd0);
  endtask

  task automatic run_layer(input int nch, input logic [7:0] inb, input logic [7:0] outb,
                           input bit toggle, input string tag);
    exp_q.delete();
    push_expected(nch, inb, outb);
    clear_counts();
    rd_gnt = 1'b1;
    pulse_start(nch, inb, outb);
    wait_done(toggle, tag);
    chk({tag, "_vin_count"}, vin_cnt, 32'(nch * 16));
    chk({tag, "_eng_rst_cycles"}, erst_cnt, 32'(nch));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    for (int i = 0; i < 16; i++) mem[8'h40 + i] = 8'h80;
    mem[8'h45] = 8'hff;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
    chk("rst_eng_rst", {31'd0, eng_rst}, 32'd0);
    chk("rst_eng_valid_in", {31'd0, eng_valid_in}, 32'd0);
    chk("rst_eng_pixel_in", {24'd0, eng_pixel_in}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_layer(1, 8'h00, 8'h80, 1'b0, "t1");
    chk("t1_last_wr_latency", last_wr_cyc - last_gnt_cyc, 32'd2);
    chk("t1_done_count", done_cnt, 32'd1);

    run_layer(2, 8'h00, 8'h80, 1'b0, "t2");

    run_layer(1, 8'h40, 8'h90, 1'b0, "t3_neg");

    run_layer(1, 8'h00, 8'h80, 1'b1, "t4_gnt_toggle");

    clear_counts();
    num_channels = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_done_early", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("t5_done_at_2", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("t5_done_after", {31'd0, done}, 32'd0);
    chk("t5_rd_count", rd_cnt, 32'd0);
    chk("t5_wr_count", wr_cnt, 32'd0);

    clear_counts();
    ignore_wr = 1'b1;
    pulse_start(1, 8'h00, 8'h80);
    for (int n = 0; n < 200 && gnt_cnt < 6; n++) begin
      @(posedge clk); #1;
    end
    chk("t6_six_grants", gnt_cnt, 32'd6);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_rd_en", {31'd0, rd_en}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_done_abort", done_cnt, 32'd0);
    ignore_wr = 1'b0;

    exp_q.delete();
    push_expected(1, 8'h00, 8'h80);
    clear_counts();
    pulse_start(1, 8'h00, 8'h80);
    repeat (3) @(posedge clk);
    #1;
    pulse_start(3, 8'h40, 8'h10);
    wait_done(1'b0, "t6_rerun");
    chk("t6_vin_count", vin_cnt, 32'd16);
    chk("t6_eng_rst_cycles", erst_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
